// File: rtl/bpsk_map_tx.sv
// BPSK transmit mapper: accepts bytes over valid/ready and emits them LSB-first,
// one +/-AMP I sample per clock, each symbol held for SPS cycles. Q is always zero.
module bpsk_map_tx #(
  parameter logic signed [10:0] AMP = 11'sd511,
  parameter int unsigned        SPS = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               valid_i,
  input  logic [7:0]         data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic signed [10:0] ar,
  output logic signed [10:0] ai,
  output logic               busy
);

  localparam logic StIdle = 1'b0;
  localparam logic StSend = 1'b1;

  localparam logic [7:0]         SampLast = 8'(SPS - 1);
  localparam logic signed [10:0] AmpNeg   = -AMP;

  logic               state_q, state_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         samp_cnt_q, samp_cnt_d;
  logic signed [10:0] ar_q, ar_d;
  logic               valid_q, valid_d;

  logic       last_samp;
  logic       accept;
  logic [2:0] bit_nxt;

  assign last_samp = (samp_cnt_q == SampLast);
  assign bit_nxt   = bit_idx_q + 3'd1;

  // Ready on the final sample of a byte lets the next byte follow with no gap.
  assign ready_o = (state_q == StIdle) || ((bit_idx_q == 3'd7) && last_samp);
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    samp_cnt_d = samp_cnt_q;
    ar_d       = ar_q;
    valid_d    = valid_q;

    if (accept) begin
      state_d    = StSend;
      shreg_d    = data_i;
      bit_idx_d  = 3'd0;
      samp_cnt_d = 8'd0;
      ar_d       = data_i[0] ? AMP : AmpNeg;
      valid_d    = 1'b1;
    end else if (state_q == StSend) begin
      if (!last_samp) begin
        samp_cnt_d = samp_cnt_q + 8'd1;
      end else if (bit_idx_q != 3'd7) begin
        samp_cnt_d = 8'd0;
        bit_idx_d  = bit_nxt;
        ar_d       = shreg_q[bit_nxt] ? AMP : AmpNeg;
      end else begin
        state_d    = StIdle;
        samp_cnt_d = 8'd0;
        bit_idx_d  = 3'd0;
        ar_d       = '0;
        valid_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      samp_cnt_q <= '0;
      ar_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      samp_cnt_q <= samp_cnt_d;
      ar_q       <= ar_d;
      valid_q    <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign busy    = valid_q;
  assign ar      = ar_q;
  assign ai      = '0;

endmodule

// File: doc/bpsk_map_tx.md
Name: bpsk_map_tx

Overview:
- Transmit-side BPSK mapper. Accepts bytes over a valid/ready handshake and serialises them LSB-first.
- Each bit maps to a signed 11-bit I/Q sample pair: bit 1 -> +AMP, bit 0 -> -AMP, Q held at 0.
- Each symbol is held for SPS sample cycles.
- Feeds the channel/DAC path. It is the counterpart of the team's BPSK demapper, which decides bit = (I > 0).

Parameters:
- AMP, 11'sd511, positive symbol amplitude; legal range 1..1023.
- SPS, 4, samples (clock cycles) per symbol; legal range 1..255.

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, asynchronous, active-low.
- valid_i  input  1  data_i holds a byte to send.
- data_i  input  8  byte to transmit; bit 0 goes first.
- ready_o  output  1  block accepts data_i this cycle.
- valid_o  output  1  ar/ai hold a valid sample.
- ar  output  11 signed  I sample.
- ai  output  11 signed  Q sample, always 0.
- busy  output  1  a byte is in transmission; equal to valid_o.

Behaviour:
- Reset: state IDLE, valid_o=0, ar=0, ai=0, busy=0, shift register=0, bit_idx=0, samp_cnt=0. ready_o=1 while in reset-released IDLE.
- Reset is asynchronous and active-low on all registers. Asserting it mid-byte drops the remainder immediately; no partial symbol is emitted after release.
- States: IDLE, SEND.
- Counters: bit_idx (0..7) and samp_cnt (0..SPS-1) always describe the sample currently driven on ar.
- ready_o is combinational from registers:
  - 1 in IDLE;
  - in SEND, 1 only when bit_idx==7 && samp_cnt==SPS-1 (the last sample of the byte);
  - 0 otherwise.
- Accept = valid_i && ready_o, sampled at the rising edge.
- On accept, at that same edge:
  - shift register <= data_i;
  - ar <= data_i[0] ? AMP : -AMP;
  - ai <= 0; valid_o <= 1; bit_idx <= 0; samp_cnt <= 0; state <= SEND.
- Latency: the first sample appears the cycle after the handshake cycle.
- SEND, no accept, samp_cnt < SPS-1: samp_cnt++; ar unchanged.
- SEND, no accept, samp_cnt == SPS-1, bit_idx < 7: samp_cnt <= 0; bit_idx++; ar <= next bit (shreg[bit_idx+1]) ? AMP : -AMP.
- SEND, no accept, samp_cnt == SPS-1, bit_idx == 7: state <= IDLE; valid_o <= 0; ar <= 0.
- Back-to-back: an accept on the last sample loads the new byte per the accept rule. The stream has no gap: exactly 8*SPS contiguous valid cycles per byte.
- Per byte, valid_o is high for exactly 8*SPS cycles; ar changes value only at symbol boundaries.
- valid_i while ready_o=0 is ignored and must not corrupt data in flight. The upstream holds data_i until accepted.
- SPS=1: every sample is a symbol boundary; ready_o is high on each byte's 8th cycle.
- Arithmetic: -AMP is the two's complement of AMP in 11 bits. No saturation is needed for AMP in the legal range.
- ai is constant 0 in all states.

Test Plan:
- Single byte, SPS=4, AMP=511: byte 0xA5 accepted from IDLE.
  - Required: valid_o high 32 cycles starting the cycle after the handshake.
  - ar pattern in 4-cycle groups: +511,-511,+511,-511,-511,+511,-511,+511.
  - Then valid_o=0, ar=0, ready_o=1.
- Back-to-back: valid_i held high with 0xFF then 0x00.
  - Required: ready_o pulses on cycle 32 of the first byte only; 64 contiguous valid cycles, 32 of +511 then 32 of -511.
- Ignore while busy: data_i changed to 0x3C mid-byte with valid_i=1 and ready_o=0.
  - Required: the in-flight byte's samples are unchanged; 0x3C is accepted only at the last-sample handshake.
- Reset mid-operation: RST driven low at sample 10 of a byte.
  - Required: valid_o, ar, busy go 0 immediately, asynchronously; after release ready_o=1 and no residual samples.
- SPS=1, AMP=1023: bytes 0x01 and 0x80 streamed.
  - Required: 16 valid cycles; ar = +1023 then 7×-1023, then 7×-1023 then +1023.
- Loopback: output fed into the BPSK demapper with 256 random bytes and SPS=4.
  - Required: the recovered bit stream, sampled mid-symbol, equals the input LSB-first with zero errors.
